// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// The optional zero-operand shortcut is enabled by defining BOOTH_ZERO_SKIP_EN.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recode window {Q[1:0], q_m1} values and the multiple of M each one selects
  localparam logic [2:0] RC_ZERO_LO = 3'b000;  //  0
  localparam logic [2:0] RC_P1_A    = 3'b001;  // +M
  localparam logic [2:0] RC_P1_B    = 3'b010;  // +M
  localparam logic [2:0] RC_P2      = 3'b011;  // +2M
  localparam logic [2:0] RC_M2      = 3'b100;  // -2M
  localparam logic [2:0] RC_M1_A    = 3'b101;  // -M
  localparam logic [2:0] RC_M1_B    = 3'b110;  // -M
  localparam logic [2:0] RC_ZERO_HI = 3'b111;  //  0

  function automatic int booth_iters(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth digit recoder: maps a 3-bit multiplier window to sign,
// magnitude-of-two and zero flags for the partial-product selector.
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] code,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  always_comb begin
    neg  = 1'b0;
    two  = 1'b0;
    zero = 1'b0;
    case (code)
      RC_ZERO_LO, RC_ZERO_HI: zero = 1'b1;
      RC_P1_A, RC_P1_B:       ;
      RC_P2:                  two = 1'b1;
      RC_M2: begin
        neg = 1'b1;
        two = 1'b1;
      end
      RC_M1_A, RC_M1_B:       neg = 1'b1;
      default:                zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier retiring two multiplier bits per clock,
// with signed/unsigned mode and edge-qualified Start. Optional: BOOTH_ZERO_SKIP_EN.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Signed,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           Busy,
  output logic           Finish,
  output logic [2*N-1:0] FProduct
);

  localparam int W  = N + 2;
  localparam int K  = booth_iters(N);
  localparam int CW = $clog2(K + 1);

  state_t          state;
  logic            start_d;
  logic [W+1:0]    a;
  logic [W-1:0]    q;
  logic [W-1:0]    m;
  logic            q_m1;
  logic [CW-1:0]   cnt;
  logic            launch;
  logic            neg;
  logic            two;
  logic            zero;
  logic [W+1:0]    m_ext;
  logic [W+1:0]    term;
  logic [W+1:0]    sum;
  logic [2*W+2:0]  shifted;
`ifdef BOOTH_ZERO_SKIP_EN
  logic            skip;
`endif

  booth_r4_recode u_recode (
    .code ({q[1:0], q_m1}),
    .neg  (neg),
    .two  (two),
    .zero (zero)
  );

  assign launch = ((state == IDLE) || (state == DONE)) && Start && !start_d;
  assign m_ext  = {{2{m[W-1]}}, m};

  // One Booth step: add the selected multiple, then arithmetic-shift {A,Q,q_m1} by two
  always_comb begin
    term    = '0;
    sum     = '0;
    shifted = '0;
    if (!zero)
      term = two ? {m_ext[W:0], 1'b0} : m_ext;
    sum     = neg ? (a - term) : (a + term);
    shifted = {{2{sum[W+1]}}, sum, q[W-1:1]};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      start_d  <= 1'b0;
      Busy     <= 1'b0;
      Finish   <= 1'b0;
      FProduct <= '0;
      a        <= '0;
      q        <= '0;
      m        <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
      skip     <= 1'b0;
`endif
    end else begin
      start_d <= Start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            m      <= {{2{Signed & Mcand[N-1]}}, Mcand};
            q      <= {{2{Signed & Mplier[N-1]}}, Mplier};
            a      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            Finish <= 1'b0;
            Busy   <= 1'b1;
            state  <= CALC;
`ifdef BOOTH_ZERO_SKIP_EN
            skip   <= (Mplier == '0) || (Mcand == '0);
`endif
          end
        end
        CALC: begin
`ifdef BOOTH_ZERO_SKIP_EN
          if (skip) begin
            FProduct <= '0;
            Finish   <= 1'b1;
            Busy     <= 1'b0;
            skip     <= 1'b0;
            state    <= DONE;
          end else
`endif
          begin
            a    <= shifted[2*W+2:W+1];
            q    <= shifted[W:1];
            q_m1 <= shifted[0];
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(K - 1)) begin
              FProduct <= shifted[2*N:1];
              Finish   <= 1'b1;
              Busy     <= 1'b0;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult (N=8): directed vector table,
// hand-written Start/Reset corner sequences and a randomised sweep vs a reference multiply.
module tb_booth_radix4_mult;

  localparam int N = 8;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 5;
`endif

  logic           clk;
  logic           Reset;
  logic           Start;
  logic           Signed;
  logic [N-1:0]   Mplier;
  logic [N-1:0]   Mcand;
  logic           Busy;
  logic           Finish;
  logic [2*N-1:0] FProduct;

  int checks;
  int failures;

  typedef struct {
    logic           sgn;
    logic [N-1:0]   mplier;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] product;
    int             latency;
  } vec_t;

  vec_t vecs[8];

  booth_radix4_mult #(.N(N)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .Start    (Start),
    .Signed   (Signed),
    .Mplier   (Mplier),
    .Mcand    (Mcand),
    .Busy     (Busy),
    .Finish   (Finish),
    .FProduct (FProduct)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [2*N-1:0] ref_mult(input logic sgn, input logic [N-1:0] x,
                                              input logic [N-1:0] y);
    longint xv;
    longint yv;
    longint p;
    xv = sgn ? longint'($signed(x)) : longint'(x);
    yv = sgn ? longint'($signed(y)) : longint'(y);
    p  = xv * yv;
    return p[2*N-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Re-arm Start low for one edge, launch, and count edges until Finish is seen
  task automatic applyStimulus(input logic sgn, input logic [N-1:0] mp, input logic [N-1:0] mc,
                               output int edges);
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    Signed = sgn;
    Mplier = mp;
    Mcand  = mc;
    Start  = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    while (!Finish && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    Start = 1'b0;
    if (!Finish) checkOutput("finish_timeout", 32'(Finish), 32'd1);
  endtask

  initial begin
    int edges;
    int rises;
    int busy_cycles;
    logic prev_fin;
    logic [N-1:0]   rmp;
    logic [N-1:0]   rmc;
    logic           rsg;
    logic [2*N-1:0] exp_p;
    int             exp_lat;

    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000, 5};
    vecs[1] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 5};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 5};
    vecs[4] = '{1'b0, 8'h03, 8'h05, 16'h000F, 5};
    vecs[5] = '{1'b0, 8'h12, 8'h34, 16'h03A8, 5};
    vecs[6] = '{1'b0, 8'h00, 8'h9C, 16'h0000, ZERO_LAT};
    vecs[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 5};

    Reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    Mplier = '0;
    Mcand  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_finish", 32'(Finish), 32'd0);
    checkOutput("reset_product", 32'(FProduct), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].mplier, vecs[i].mcand, edges);
      checkOutput($sformatf("vec%0d_product", i), 32'(FProduct), 32'(vecs[i].product));
      checkOutput($sformatf("vec%0d_latency", i), 32'(edges), 32'(vecs[i].latency));
      repeat (3) @(negedge clk);
      checkOutput($sformatf("vec%0d_hold_finish", i), 32'(Finish), 32'd1);
      checkOutput($sformatf("vec%0d_hold_product", i), 32'(FProduct), 32'(vecs[i].product));
    end

    // Start held high 12 cycles must give exactly one operation
    @(negedge clk);
    Signed = 1'b0;
    Mplier = 8'h03;
    Mcand  = 8'h05;
    Start  = 1'b1;
    rises = 0;
    busy_cycles = 0;
    prev_fin = Finish;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 11) Start = 1'b0;
      if (Busy) busy_cycles++;
      if (Finish && !prev_fin) rises++;
      prev_fin = Finish;
    end
    checkOutput("held_start_rises", 32'(rises), 32'd1);
    checkOutput("held_start_busy", 32'(busy_cycles), 32'd5);
    checkOutput("held_start_product", 32'(FProduct), 32'h000F);

    // A second Start rise mid-CALC is neither honoured nor queued
    @(negedge clk);
    Mplier = 8'h03;
    Mcand  = 8'h05;
    Start  = 1'b1;
    rises = 0;
    busy_cycles = 0;
    prev_fin = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) Start = 1'b0;
      if (c == 1) begin
        Mplier = 8'h07;
        Mcand  = 8'h07;
        Start  = 1'b1;
      end
      if (Busy) busy_cycles++;
      if (Finish && !prev_fin) rises++;
      prev_fin = Finish;
    end
    Start = 1'b0;
    checkOutput("restart_rises", 32'(rises), 32'd1);
    checkOutput("restart_busy", 32'(busy_cycles), 32'd5);
    checkOutput("restart_product", 32'(FProduct), 32'h000F);

    // Reset on the third CALC edge aborts with no partial result
    @(negedge clk);
    Signed = 1'b1;
    Mplier = 8'h7F;
    Mcand  = 8'h7F;
    Start  = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_calc_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_finish", 32'(Finish), 32'd0);
    checkOutput("abort_product", 32'(FProduct), 32'd0);
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    applyStimulus(1'b0, 8'h12, 8'h34, edges);
    checkOutput("post_reset_product", 32'(FProduct), 32'h03A8);
    checkOutput("post_reset_latency", 32'(edges), 32'd5);

    // Randomised sweep against the reference multiply
    for (int r = 0; r < 1000; r++) begin
      rsg = 1'($urandom_range(0, 1));
      rmp = N'($urandom);
      rmc = N'($urandom);
      if (r % 97 == 0) rmp = '0;
      exp_p   = ref_mult(rsg, rmp, rmc);
      exp_lat = ((rmp == '0) || (rmc == '0)) ? ZERO_LAT : 5;
      applyStimulus(rsg, rmp, rmc, edges);
      checkOutput($sformatf("rand%0d_product", r), 32'(FProduct), 32'(exp_p));
      checkOutput($sformatf("rand%0d_latency", r), 32'(edges), 32'(exp_lat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
